// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / mret sequencer: captures a trap or mret request, then
// replays it as an ordered series of single-port CSR writes followed by one fetch redirect.
module trap_sequencer #(
    parameter logic [1:0]  RESET_PRIV    = 2'b11,
    parameter logic [63:0] MSTATUS_WMASK = 64'h7e79bb
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic [63:0] exc_cause,
    input  logic [63:0] exc_pc,
    input  logic [63:0] exc_tval,
    input  logic        mret_valid,
    input  logic        int_window,
    input  logic [63:0] int_pc,
    input  logic        msip,
    input  logic        mtip,
    input  logic        meip,
    input  logic [63:0] mstatus_i,
    input  logic [63:0] mtvec_i,
    input  logic [63:0] mepc_i,
    input  logic [63:0] mie_i,
    output logic        csr_we,
    output logic [11:0] csr_waddr,
    output logic [63:0] csr_wdata,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    output logic        busy,
    output logic [1:0]  priv_o
);

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;

    typedef enum logic [2:0] {
        IDLE, W_EPC, W_CAUSE, W_TVAL, W_STAT, R_STAT, REDIR
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [11:0] waddr_q, waddr_d;
    logic [63:0] wdata_q, wdata_d;
    logic        rv_q, rv_d;
    logic [63:0] rpc_q, rpc_d;
    logic        busy_q, busy_d;
    logic [1:0]  priv_q, priv_d;

    // Request snapshot, refreshed every IDLE cycle so the accept-cycle values stick.
    logic [63:0] cause_q, tval_q, mstat_q, mtvec_q, mepc_q;
    logic [1:0]  opriv_q;
    logic        is_int_q;
    logic [3:0]  code_q;

    logic [2:0]  pend;
    logic        int_en;
    logic        take_int;
    logic [3:0]  int_code;
    logic        unused_mie;

    function automatic logic [63:0] merge_wmask(input logic [63:0] nv, input logic [63:0] ov);
        return (nv & MSTATUS_WMASK) | (ov & ~MSTATUS_WMASK);
    endfunction

    function automatic logic [63:0] trap_mstatus(input logic [63:0] m, input logic [1:0] p);
        logic [63:0] n;
        n        = m;
        n[7]     = m[3];
        n[3]     = 1'b0;
        n[12:11] = p;
        return merge_wmask(n, m);
    endfunction

    function automatic logic [63:0] mret_mstatus(input logic [63:0] m);
        logic [63:0] n;
        n        = m;
        n[3]     = m[7];
        n[7]     = 1'b1;
        n[12:11] = 2'b00;
        return merge_wmask(n, m);
    endfunction

    function automatic logic [63:0] trap_target(input logic [63:0] tvec, input logic intr,
                                                input logic [3:0] code);
        logic [63:0] base;
        base = tvec & ~64'd3;
        if (tvec[1:0] == 2'b01 && intr)
            return base + {58'd0, code, 2'b00};
        return base;
    endfunction

    assign pend       = {meip & mie_i[11], mtip & mie_i[7], msip & mie_i[3]};
    assign int_en     = (priv_q != 2'b11) || mstatus_i[3];
    assign take_int   = int_window && int_en && (pend != 3'b000);
    assign int_code   = pend[2] ? 4'd11 : (pend[0] ? 4'd3 : 4'd7);
    assign unused_mie = ^{mie_i[63:12], mie_i[10:8], mie_i[6:4], mie_i[2:0]};

    always_comb begin
        state_d = state_q;
        we_d    = 1'b0;
        waddr_d = 12'h000;
        wdata_d = 64'd0;
        rv_d    = 1'b0;
        rpc_d   = 64'd0;
        priv_d  = priv_q;
        case (state_q)
            IDLE: begin
                if (take_int) begin
                    state_d = W_EPC;
                    we_d    = 1'b1;
                    waddr_d = A_MEPC;
                    wdata_d = int_pc & ~64'd3;
                end else if (exc_valid) begin
                    state_d = W_EPC;
                    we_d    = 1'b1;
                    waddr_d = A_MEPC;
                    wdata_d = exc_pc & ~64'd3;
                end else if (mret_valid) begin
                    state_d = R_STAT;
                    we_d    = 1'b1;
                    waddr_d = A_MSTATUS;
                    wdata_d = mret_mstatus(mstatus_i);
                    priv_d  = mstatus_i[12:11];
                end
            end
            W_EPC: begin
                state_d = W_CAUSE;
                we_d    = 1'b1;
                waddr_d = A_MCAUSE;
                wdata_d = cause_q;
            end
            W_CAUSE: begin
                state_d = W_TVAL;
                we_d    = 1'b1;
                waddr_d = A_MTVAL;
                wdata_d = tval_q;
            end
            W_TVAL: begin
                state_d = W_STAT;
                we_d    = 1'b1;
                waddr_d = A_MSTATUS;
                wdata_d = trap_mstatus(mstat_q, opriv_q);
                priv_d  = 2'b11;
            end
            W_STAT: begin
                state_d = REDIR;
                rv_d    = 1'b1;
                rpc_d   = trap_target(mtvec_q, is_int_q, code_q);
            end
            R_STAT: begin
                state_d = REDIR;
                rv_d    = 1'b1;
                rpc_d   = mepc_q;
            end
            REDIR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            waddr_q <= 12'h000;
            wdata_q <= 64'd0;
            rv_q    <= 1'b0;
            rpc_q   <= 64'd0;
            busy_q  <= 1'b0;
            priv_q  <= RESET_PRIV;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            rv_q    <= rv_d;
            rpc_q   <= rpc_d;
            busy_q  <= busy_d;
            priv_q  <= priv_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE) begin
            cause_q  <= take_int ? {1'b1, 59'd0, int_code} : exc_cause;
            tval_q   <= take_int ? 64'd0 : exc_tval;
            mstat_q  <= mstatus_i;
            mtvec_q  <= mtvec_i;
            mepc_q   <= mepc_i;
            opriv_q  <= priv_q;
            is_int_q <= take_int;
            code_q   <= int_code;
        end
    end

    assign csr_we         = we_q;
    assign csr_waddr      = waddr_q;
    assign csr_wdata      = wdata_q;
    assign redirect_valid = rv_q;
    assign redirect_pc    = rpc_q;
    assign busy           = busy_q;
    assign priv_o         = priv_q;

endmodule
